// File: rtl/imem_line_fetch_pkg.sv
// rtl/imem_line_fetch_pkg.sv - shared widths, line geometry and fetch state encoding
// Ports: none (package).
package imem_line_fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned BUS_WID = 64;
  localparam int unsigned BUS_LEN = BUS_WID / 32;
  localparam int unsigned BUS_OFF = $clog2(BUS_WID / 8);

  localparam int unsigned MAX_OUT_DEF = 2;
  localparam int unsigned OUT_W_DEF   = 2;

  // Byte stride between consecutive lines and the mask of in-line offset bits.
  localparam logic [XLEN-1:0] LINE_BYTES = XLEN'(BUS_WID / 8);
  localparam logic [XLEN-1:0] LINE_MASK  = LINE_BYTES - XLEN'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/imem_line_fetch_credit_cnt.sv
// rtl/imem_line_fetch_credit_cnt.sv - outstanding-read and stale-response tracker
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   issue      a read request was accepted this cycle
//   resp       a read response arrives this cycle
//   flush      redirect this cycle; everything in flight becomes stale
//   can_issue  fewer than MAX_OUT reads outstanding
//   drop       the response this cycle must not reach the consumer
module fetch_credit_cnt #(
  parameter int unsigned MAX_OUT = 2,
  parameter int unsigned OUT_W   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  input  logic resp,
  input  logic flush,
  output logic can_issue,
  output logic drop
);

  logic [OUT_W-1:0] out_cnt_q, out_cnt_d;
  logic [OUT_W-1:0] disc_cnt_q, disc_cnt_d;

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (issue && !resp) begin
      out_cnt_d = out_cnt_q + OUT_W'(1);
    end else if (resp && !issue && out_cnt_q != '0) begin
      out_cnt_d = out_cnt_q - OUT_W'(1);
    end

    disc_cnt_d = disc_cnt_q;
    if (flush) begin
      // Everything still in flight after this cycle's response is stale.
      disc_cnt_d = (resp && out_cnt_q != '0) ? out_cnt_q - OUT_W'(1) : out_cnt_q;
    end else if (resp && disc_cnt_q != '0) begin
      disc_cnt_d = disc_cnt_q - OUT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_cnt_q  <= '0;
      disc_cnt_q <= '0;
    end else begin
      out_cnt_q  <= out_cnt_d;
      disc_cnt_q <= disc_cnt_d;
    end
  end

  assign can_issue = (out_cnt_q < OUT_W'(MAX_OUT));
  // A response in the redirect cycle is stale even when disc_cnt is still zero.
  assign drop      = resp && (flush || disc_cnt_q != '0);

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst)
    !(resp && out_cnt_q == '0));
  a_out_bound: assert property (@(posedge clk) disable iff (!rst)
    out_cnt_q <= OUT_W'(MAX_OUT));

endmodule

// File: rtl/imem_line_fetch.sv
// rtl/imem_line_fetch.sv - line-aligned instruction fetch requester with redirect discard
// Macro IMEM_RESP_REG_EN: registers the line outputs (1-cycle latency after imem_resp);
// undefined gives combinational line outputs with line_data forced to 0 when idle.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   jump_vld, jump_pc              redirect strobe and halfword-aligned target
//   buffer_free                    consumer can take one more line
//   imem_req, imem_addr, imem_gnt  request handshake to instruction memory
//   imem_resp, imem_rdata, imem_rerr  read response and access fault
//   line_vld, line_data, line_err  line delivered to the instruction buffer
module imem_line_fetch
  import imem_line_fetch_pkg::*;
#(
  parameter int unsigned MAX_OUT = MAX_OUT_DEF,
  parameter int unsigned OUT_W   = OUT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               jump_vld,
  input  logic [XLEN-1:0]    jump_pc,
  input  logic               buffer_free,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_resp,
  input  logic [BUS_WID-1:0] imem_rdata,
  input  logic               imem_rerr,
  output logic               line_vld,
  output logic [BUS_WID-1:0] line_data,
  output logic               line_err
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
  logic            pend_q, pend_d;
  logic            can_issue, drop, issue, deliver;

  fetch_credit_cnt #(
    .MAX_OUT (MAX_OUT),
    .OUT_W   (OUT_W)
  ) u_credit (
    .clk       (clk),
    .rst       (rst),
    .issue     (issue),
    .resp      (imem_resp),
    .flush     (jump_vld),
    .can_issue (can_issue),
    .drop      (drop)
  );

  // pend_q keeps an ungranted request (and its address) stable even if
  // buffer_free drops or the state leaves RUN; only a jump withdraws it.
  assign imem_req  = !jump_vld && (pend_q || (state_q == RUN && buffer_free && can_issue));
  assign imem_addr = fetch_addr_q;
  assign issue     = imem_req && imem_gnt;
  assign deliver   = imem_resp && !drop;

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    pend_d       = imem_req && !imem_gnt;
    if (jump_vld) begin
      state_d      = RUN;
      fetch_addr_d = jump_pc & ~LINE_MASK;
    end else begin
      if (issue) begin
        fetch_addr_d = fetch_addr_q + LINE_BYTES;
      end
      if (state_q == RUN && deliver && imem_rerr) begin
        state_d = HOLD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      pend_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      pend_q       <= pend_d;
    end
  end

`ifdef IMEM_RESP_REG_EN
  logic               line_vld_q, line_vld_d;
  logic [BUS_WID-1:0] line_data_q, line_data_d;
  logic               line_err_q, line_err_d;

  always_comb begin
    line_vld_d  = deliver;
    line_data_d = deliver ? imem_rdata : '0;
    line_err_d  = deliver && imem_rerr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_vld_q  <= 1'b0;
      line_data_q <= '0;
      line_err_q  <= 1'b0;
    end else begin
      line_vld_q  <= line_vld_d;
      line_data_q <= line_data_d;
      line_err_q  <= line_err_d;
    end
  end

  // A redirect arriving while the registered line is presented makes it stale.
  assign line_vld  = line_vld_q && !jump_vld;
  assign line_data = line_data_q;
  assign line_err  = line_err_q && !jump_vld;
`else
  assign line_vld  = deliver;
  assign line_data = deliver ? imem_rdata : '0;
  assign line_err  = deliver && imem_rerr;
`endif

endmodule

// File: tb/tb_imem_line_fetch.sv
// tb/tb_imem_line_fetch.sv - self-checking bench for imem_line_fetch against an epoch-tagged memory model
module tb_imem_line_fetch;
  import imem_line_fetch_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               jump_vld;
  logic [XLEN-1:0]    jump_pc;
  logic               buffer_free;
  logic               imem_req;
  logic [XLEN-1:0]    imem_addr;
  logic               imem_gnt;
  logic               imem_resp;
  logic [BUS_WID-1:0] imem_rdata;
  logic               imem_rerr;
  logic               line_vld;
  logic [BUS_WID-1:0] line_data;
  logic               line_err;

  imem_line_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .jump_vld    (jump_vld),
    .jump_pc     (jump_pc),
    .buffer_free (buffer_free),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_resp   (imem_resp),
    .imem_rdata  (imem_rdata),
    .imem_rerr   (imem_rerr),
    .line_vld    (line_vld),
    .line_data   (line_data),
    .line_err    (line_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } rd_t;

  rd_t         q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          lat = 1;
  int          last_due = 0;
  int          m_epoch = 0;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] err_addr = 32'h1;
  logic        m_run = 1'b0;
  logic        m_hold = 1'b0;
  logic        m_pend = 1'b0;

  function automatic logic [63:0] memval(input logic [31:0] a);
    return {a ^ 32'hA5A5_0000, ~a + 32'h1357};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock of stimulus plus checking. Caller sets jump_vld/jump_pc/buffer_free/imem_gnt.
  task automatic cycle();
    rd_t  r;
    logic have, exp_req, dlv, hold_n;
    int   due;
    have = (q.size() != 0) && (q[0].due == cyc);
    if (have) begin
      imem_resp  = 1'b1;
      imem_rdata = memval(q[0].addr);
      imem_rerr  = (q[0].addr == err_addr);
    end else begin
      imem_resp  = 1'b0;
      imem_rdata = {$urandom, $urandom};
      imem_rerr  = $urandom_range(0, 1) == 1;
    end
    exp_req = !jump_vld && (m_pend ||
              (m_run && !m_hold && buffer_free && q.size() < MAX_OUT_DEF));
    #4;
    chk("imem_req", {63'd0, imem_req}, {63'd0, exp_req});
    if (exp_req) chk("imem_addr", {32'd0, imem_addr}, {32'd0, m_addr});
    hold_n = m_hold;
    dlv = 1'b0;
    if (have) begin
      r = q.pop_front();
      dlv = (r.epoch == m_epoch) && !jump_vld;
      if (dlv) begin
        chk("line_data", line_data, memval(r.addr));
        chk("line_err", {63'd0, line_err}, {63'd0, r.addr == err_addr});
        if (r.addr == err_addr && m_run) hold_n = 1'b1;
      end
    end
    chk("line_vld", {63'd0, line_vld}, {63'd0, dlv});
    if (!dlv) chk("line_data_idle", line_data, 64'd0);
    if (exp_req && imem_gnt) begin
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = due;
      q.push_back('{addr: m_addr, epoch: m_epoch, due: due});
      m_addr = m_addr + 32'd8;
    end
    m_pend = exp_req && !imem_gnt;
    if (jump_vld) begin
      m_epoch++;
      m_addr = jump_pc & 32'hFFFF_FFF8;
      m_run  = 1'b1;
      hold_n = 1'b0;
      m_pend = 1'b0;
    end
    m_hold = hold_n;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic jump(input logic [31:0] pc);
    jump_vld = 1'b1;
    jump_pc  = pc;
    cycle();
    jump_vld = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    jump_vld = 1'b0;
    jump_pc = '0;
    buffer_free = 1'b0;
    imem_gnt = 1'b0;
    imem_resp = 1'b0;
    imem_rdata = '0;
    imem_rerr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imem_req", {63'd0, imem_req}, 64'd0);
    chk("rst_imem_addr", {32'd0, imem_addr}, 64'd0);
    chk("rst_line_vld", {63'd0, line_vld}, 64'd0);
    chk("rst_line_data", line_data, 64'd0);
    chk("rst_line_err", {63'd0, line_err}, 64'd0);
    rst = 1'b1;

    // Idle: nothing happens without a jump, even with buffer space and grants.
    buffer_free = 1'b1;
    imem_gnt = 1'b1;
    repeat (10) cycle();

    // Jump to a misaligned target, 1-cycle memory.
    lat = 1;
    jump(32'h0000_1006);
    repeat (6) cycle();

    // Drain, then fill two outstanding reads with slow memory and redirect.
    buffer_free = 1'b0;
    repeat (6) cycle();
    lat = 4;
    buffer_free = 1'b1;
    repeat (2) cycle();
    lat = 1;
    jump(32'h0000_2000);
    repeat (8) cycle();

    // Consumer backpressure mid-stream.
    buffer_free = 1'b0;
    repeat (3) cycle();
    buffer_free = 1'b1;
    repeat (4) cycle();

    // Grant withheld for three cycles; buffer_free drops while the request is pending.
    imem_gnt = 1'b0;
    cycle();
    buffer_free = 1'b0;
    cycle();
    buffer_free = 1'b1;
    cycle();
    imem_gnt = 1'b1;
    repeat (4) cycle();

    // Access fault at 0x3008 parks the fetcher until the next jump.
    err_addr = 32'h0000_3008;
    jump(32'h0000_3000);
    repeat (10) cycle();
    jump(32'h0000_4002);
    repeat (5) cycle();

    // Address wrap at the top of the space.
    jump(32'hFFFF_FFFA);
    repeat (6) cycle();

    // Randomized traffic.
    err_addr = 32'h0000_5018;
    for (int i = 0; i < 400; i++) begin
      buffer_free = $urandom_range(0, 3) != 0;
      imem_gnt    = $urandom_range(0, 2) != 0;
      lat         = $urandom_range(1, 4);
      jump_vld    = $urandom_range(0, 19) == 0;
      jump_pc     = 32'h0000_5000 + 32'($urandom_range(0, 63)) * 32'd2;
      cycle();
    end
    jump_vld = 1'b0;
    buffer_free = 1'b1;
    imem_gnt = 1'b1;
    repeat (10) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
